// File: rtl/dp_pkg.sv
// Shared datapath definitions: word and register-address types used by the
// operand stage, the shifter and the ALU.
package dp_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/regfile.sv
// General-purpose register file: synchronous-reset storage, one-hot write
// decode and two independent combinational read ports.
module regfile
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned NREGS = 1 << REG_ADDR_W,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] rd_a_raw,
  output logic [WIDTH-1:0] rd_b_raw
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [NREGS-1:0] wr_en;

  // One-hot write decode; all zero when no write is requested.
  always_comb begin
    wr_en = '0;
    if (write) begin
      wr_en[writenum] = 1'b1;
    end
  end

  // Per-register storage; reset clears every entry, including R0.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else if (wr_en[i]) begin
        mem_q[i] <= data_in;
      end
    end
  end

  // Read ports see only committed contents; forwarding lives in the parent.
  assign rd_a_raw = mem_q[readnum_a];
  assign rd_b_raw = mem_q[readnum_b];

endmodule

// File: rtl/regfile_operand_stage.sv
// Operand stage: register file plus the A (ALU) and B (shifter) operand
// latches, with write-first forwarding so a latch never captures stale data.
module regfile_operand_stage
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned NREGS = 1 << REG_ADDR_W,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  input  logic             loada,
  input  logic             loadb,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out
);

  logic [WIDTH-1:0] rd_a_raw, rd_b_raw;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] a_q, b_q;

  regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .writenum  (writenum),
    .write     (write),
    .readnum_a (readnum_a),
    .readnum_b (readnum_b),
    .rd_a_raw  (rd_a_raw),
    .rd_b_raw  (rd_b_raw)
  );

  // Bypass: a write landing on the same edge as a load to that index wins.
  always_comb begin
    rd_a = rd_a_raw;
    rd_b = rd_b_raw;
    if (write && (writenum == readnum_a)) begin
      rd_a = data_in;
    end
    if (write && (writenum == readnum_b)) begin
      rd_b = data_in;
    end
  end

  // Operand latches; reset dominates the load enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (loada) a_q <= rd_a;
      if (loadb) b_q <= rd_b;
    end
  end

  assign A_out = a_q;
  assign B_out = b_q;

endmodule
